// File: rtl/shift_sequencer.sv
// Multi-cycle 32-bit shifter: one bit per clock, SLL or SRA, start-strobe / ready-pulse handshake.
// Latency N+2 cycles from the start edge to the ready pulse (N = shift amount).

// One-bit arithmetic right shift cell.
// Latency: combinational.
// Backpressure: none.
module shiftright_one (
  input  logic [31:0] din,
  output logic [31:0] dout
);

  assign dout = {din[31], din[31:1]};

endmodule

// Sequenced shifter, one bit of shift per clock with a captured direction.
// Latency: busy for N+1 cycles after the start edge, then a 1-cycle result-ready pulse.
// Backpressure: none; start strobes are ignored while busy, the caller stalls on busy.
module shift_sequencer (
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_shift,
  input  logic        ctrl_dir,
  input  logic [31:0] data_operand,
  input  logic [4:0]  data_shamt,
  output logic [31:0] data_result,
  output logic        data_resultRDY,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] acc, acc_nxt;
  logic [4:0]  cnt, cnt_nxt;
  logic        dir, dir_nxt;

  logic [31:0] sra_step;
  logic [31:0] sll_step;

  shiftright_one u_sra (
    .din  (acc),
    .dout (sra_step)
  );

  assign sll_step = {acc[30:0], 1'b0};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      acc   <= 32'h0000_0000;
      cnt   <= 5'd0;
      dir   <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      dir   <= dir_nxt;
    end
  end

  // DONE accepts a new start directly so back-to-back operations have no idle gap.
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    dir_nxt   = dir;
    case (state)
      S_IDLE, S_DONE: begin
        if (ctrl_shift) begin
          acc_nxt   = data_operand;
          cnt_nxt   = data_shamt;
          dir_nxt   = ctrl_dir;
          state_nxt = S_RUN;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (cnt == 5'd0) begin
          state_nxt = S_DONE;
        end else begin
          acc_nxt = dir ? sra_step : sll_step;
          cnt_nxt = cnt - 5'd1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign data_result    = acc;
  assign busy           = (state == S_RUN);
  assign data_resultRDY = (state == S_DONE);

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed-vector bench for shift_sequencer: table of operations plus hand-built corner sequences.
module tb_shift_sequencer;

  logic        clock;
  logic        reset;
  logic        ctrl_shift;
  logic        ctrl_dir;
  logic [31:0] data_operand;
  logic [4:0]  data_shamt;
  logic [31:0] data_result;
  logic        data_resultRDY;
  logic        busy;

  int checks = 0;
  int errors = 0;

  shift_sequencer dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_shift     (ctrl_shift),
    .ctrl_dir       (ctrl_dir),
    .data_operand   (data_operand),
    .data_shamt     (data_shamt),
    .data_result    (data_result),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        dir;
    logic [31:0] operand;
    logic [4:0]  shamt;
    logic [31:0] expected;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called at a falling edge; issues a start and checks busy/RDY cycle by cycle.
  // glitch >= 0 re-pulses ctrl_shift with a bogus operand during RUN.
  // Returns at the falling edge inside the DONE cycle.
  task automatic run_op(input logic d, input logic [31:0] op, input logic [4:0] sh,
                        input logic [31:0] exp, input int glitch, input string tag);
    ctrl_dir     = d;
    data_operand = op;
    data_shamt   = sh;
    ctrl_shift   = 1'b1;
    for (int i = 0; i <= int'(sh); i++) begin
      @(negedge clock);
      ctrl_shift = 1'b0;
      chk({tag, " busy"}, {31'd0, busy}, 32'd1);
      chk({tag, " rdy_early"}, {31'd0, data_resultRDY}, 32'd0);
      if (i == glitch) begin
        ctrl_shift   = 1'b1;
        ctrl_dir     = 1'b0;
        data_operand = 32'h0000_0001;
        data_shamt   = 5'd0;
      end
    end
    @(negedge clock);
    ctrl_shift = 1'b0;
    chk({tag, " rdy"}, {31'd0, data_resultRDY}, 32'd1);
    chk({tag, " busy_done"}, {31'd0, busy}, 32'd0);
    chk({tag, " result"}, data_result, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0]        r_op;
    logic [4:0]         r_sh;
    logic               r_dir;
    logic signed [31:0] s_op;
    logic [31:0]        r_exp;
    int                 rdy_seen;

    vecs[0] = '{1'b1, 32'h8000_0000, 5'd4,  32'hF800_0000};
    vecs[1] = '{1'b0, 32'h0000_0001, 5'd31, 32'h8000_0000};
    vecs[2] = '{1'b1, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000};
    vecs[3] = '{1'b0, 32'h1234_5678, 5'd0,  32'h1234_5678};
    vecs[4] = '{1'b1, 32'h1234_5678, 5'd0,  32'h1234_5678};
    vecs[5] = '{1'b1, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF};
    vecs[6] = '{1'b0, 32'hFFFF_FFFF, 5'd1,  32'hFFFF_FFFE};
    vecs[7] = '{1'b1, 32'h0000_F000, 5'd12, 32'h0000_000F};

    reset        = 1'b1;
    ctrl_shift   = 1'b0;
    ctrl_dir     = 1'b0;
    data_operand = 32'h0;
    data_shamt   = 5'd0;

    repeat (2) @(negedge clock);
    chk("reset result", data_result, 32'h0);
    chk("reset rdy", {31'd0, data_resultRDY}, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    @(negedge clock);
    chk("idle busy", {31'd0, busy}, 32'd0);

    // Table: each operation followed by one idle cycle where the result must hold.
    for (int v = 0; v < 8; v++) begin
      run_op(vecs[v].dir, vecs[v].operand, vecs[v].shamt, vecs[v].expected, -1,
             $sformatf("vec%0d", v));
      @(negedge clock);
      chk($sformatf("vec%0d idle_rdy", v), {31'd0, data_resultRDY}, 32'd0);
      chk($sformatf("vec%0d idle_hold", v), data_result, vecs[v].expected);
    end

    // Start ignored during RUN, then back-to-back start from DONE.
    run_op(1'b1, 32'hFFFF_0000, 5'd8, 32'hFFFF_FF00, 3, "midrun");
    run_op(1'b0, 32'h0000_000F, 5'd4, 32'h0000_00F0, -1, "b2b");
    @(negedge clock);
    chk("b2b idle", {31'd0, busy | data_resultRDY}, 32'd0);

    // Reset during RUN: outputs clear at once and the aborted op never signals ready.
    ctrl_dir     = 1'b0;
    data_operand = 32'hA5A5_A5A5;
    data_shamt   = 5'd16;
    ctrl_shift   = 1'b1;
    @(negedge clock);
    ctrl_shift = 1'b0;
    repeat (6) @(negedge clock);
    chk("abort busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    chk("abort result", data_result, 32'h0);
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort rdy", {31'd0, data_resultRDY}, 32'd0);
    @(negedge clock);
    reset    = 1'b0;
    rdy_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (data_resultRDY) rdy_seen++;
    end
    chk("abort no_rdy", rdy_seen, 32'd0);
    run_op(1'b1, 32'hA5A5_A5A5, 5'd1, 32'hD2D2_D2D2, -1, "post_reset");
    @(negedge clock);

    // Sweep against the language shift operators.
    for (int n = 0; n < 1000; n++) begin
      r_op  = $urandom;
      r_sh  = 5'($urandom_range(31, 0));
      r_dir = 1'($urandom_range(1, 0));
      s_op  = r_op;
      r_exp = r_dir ? 32'(s_op >>> r_sh) : (r_op << r_sh);
      run_op(r_dir, r_op, r_sh, r_exp, -1, $sformatf("rand%0d", n));
      if (n % 3 == 0) @(negedge clock);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
